// File: rtl/fifo_accel_bridge_pkg.sv
// Shared constants and helpers for the accelerator <-> stream FIFO bridge.
// Optional drop accounting is enabled with FIFO_ACCEL_BRIDGE_DROP_CNT_EN.
package fifo_accel_bridge_pkg;

  localparam int unsigned ACCEL_BUS_WIDTH = 16;
  localparam int unsigned DROP_CNT_WIDTH  = 16;
  localparam int unsigned MAX_PTR_WIDTH   = 32;

  // Occupancy of a ring with one sacrificed slot: (wptr - rptr) mod 2**ptr_width.
  function automatic logic [MAX_PTR_WIDTH-1:0] fifo_level(
    input logic [MAX_PTR_WIDTH-1:0] wptr,
    input logic [MAX_PTR_WIDTH-1:0] rptr,
    input int unsigned              ptr_width
  );
    logic [63:0] mask;
    mask = (64'd1 << ptr_width) - 64'd1;
    return MAX_PTR_WIDTH'((64'(wptr) - 64'(rptr)) & mask);
  endfunction

endpackage

// File: rtl/fifo_accel_bridge_sync_ring_fifo.sv
// Ring-buffer FIFO with synchronous active-high reset, show-ahead head and modular level.
// Used for both channels of fifo_accel_bridge.
module sync_ring_fifo
  import fifo_accel_bridge_pkg::*;
#(
  parameter int unsigned Width    = 8,
  parameter int unsigned PtrWidth = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_push,
  input  logic [Width-1:0]    i_data,
  input  logic                i_pop,
  output logic                o_full,
  output logic                o_empty,
  output logic [PtrWidth-1:0] o_level,
  output logic [Width-1:0]    o_head
);

  localparam int unsigned Depth = 2 ** PtrWidth;

  logic [Width-1:0]    r_mem [Depth];
  logic [PtrWidth-1:0] r_wptr;
  logic [PtrWidth-1:0] r_rptr;

  logic [PtrWidth-1:0] w_wptr_inc;
  logic                w_push_ok;
  logic                w_pop_ok;

  assign w_wptr_inc = r_wptr + PtrWidth'(1);
  assign o_full     = (w_wptr_inc == r_rptr);
  assign o_empty    = (r_wptr == r_rptr);
  assign o_head     = r_mem[r_rptr];
  assign o_level    = PtrWidth'(fifo_level(MAX_PTR_WIDTH'(r_wptr), MAX_PTR_WIDTH'(r_rptr),
                                           PtrWidth));

  // Flags are pre-edge: a push into a full ring is refused even if a pop lands on the same edge.
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= w_wptr_inc;
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + PtrWidth'(1);
      end
    end
  end

  // Storage is deliberately not reset; pointers alone define validity.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push_ok) begin
      r_mem[r_wptr] <= i_data;
    end
  end

endmodule

// File: rtl/fifo_accel_bridge.sv
// Bidirectional bridge: stream -> inbound FIFO -> accel reads; accel writes -> outbound FIFO
// -> valid/ready stream. Define FIFO_ACCEL_BRIDGE_DROP_CNT_EN to add inbound drop accounting.
module fifo_accel_bridge
  import fifo_accel_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned IN_PTR_WIDTH  = 10,
  parameter int unsigned OUT_PTR_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       accel_can_read,
  output logic                       accel_can_write,
  input  logic                       accel_read_enable,
  input  logic                       accel_write_enable,
  output logic [ACCEL_BUS_WIDTH-1:0] accel_read_data,
  input  logic [ACCEL_BUS_WIDTH-1:0] accel_write_data,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       data_in_valid,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       data_out_valid,
  input  logic                       data_out_ready,
`ifdef FIFO_ACCEL_BRIDGE_DROP_CNT_EN
  output logic [DROP_CNT_WIDTH-1:0]  in_drop_count,
  output logic                       in_overflow,
`endif
  output logic [IN_PTR_WIDTH-1:0]    in_level,
  output logic [OUT_PTR_WIDTH-1:0]   out_level
);

  logic                  w_in_full;
  logic                  w_in_empty;
  logic [DATA_WIDTH-1:0] w_in_head;
  logic                  w_out_full;
  logic                  w_out_empty;

  sync_ring_fifo #(
    .Width    (DATA_WIDTH),
    .PtrWidth (IN_PTR_WIDTH)
  ) u_in_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (data_in_valid),
    .i_data  (data_in),
    .i_pop   (accel_read_enable),
    .o_full  (w_in_full),
    .o_empty (w_in_empty),
    .o_level (in_level),
    .o_head  (w_in_head)
  );

  sync_ring_fifo #(
    .Width    (DATA_WIDTH),
    .PtrWidth (OUT_PTR_WIDTH)
  ) u_out_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (accel_write_enable),
    .i_data  (accel_write_data[DATA_WIDTH-1:0]),
    .i_pop   (data_out_ready),
    .o_full  (w_out_full),
    .o_empty (w_out_empty),
    .o_level (out_level),
    .o_head  (data_out)
  );

  assign accel_can_read  = !w_in_empty;
  assign accel_can_write = !w_out_full;
  assign data_out_valid  = !w_out_empty;
  assign accel_read_data = ACCEL_BUS_WIDTH'(w_in_head);

`ifdef FIFO_ACCEL_BRIDGE_DROP_CNT_EN
  logic [DROP_CNT_WIDTH-1:0] r_drop_count;
  logic                      r_overflow;
  logic                      w_drop;

  assign w_drop = data_in_valid && w_in_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != '1) begin
        r_drop_count <= r_drop_count + DROP_CNT_WIDTH'(1);
      end
    end
  end

  assign in_drop_count = r_drop_count;
  assign in_overflow   = r_overflow;
`endif

endmodule

// File: tb/tb_fifo_accel_bridge.sv
// Scoreboard bench for fifo_accel_bridge with a 7-entry inbound and 3-entry outbound channel.
module tb_fifo_accel_bridge;
  import fifo_accel_bridge_pkg::*;

  localparam int unsigned InCap  = 7;
  localparam int unsigned OutCap = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        accel_can_read, accel_can_write;
  logic        accel_read_enable, accel_write_enable;
  logic [15:0] accel_read_data, accel_write_data;
  logic [7:0]  data_in, data_out;
  logic        data_in_valid, data_out_valid, data_out_ready;
  logic [2:0]  in_level;
  logic [1:0]  out_level;
`ifdef FIFO_ACCEL_BRIDGE_DROP_CNT_EN
  logic [15:0] in_drop_count;
  logic        in_overflow;
`endif

  fifo_accel_bridge #(
    .DATA_WIDTH    (8),
    .IN_PTR_WIDTH  (3),
    .OUT_PTR_WIDTH (2)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .accel_can_read     (accel_can_read),
    .accel_can_write    (accel_can_write),
    .accel_read_enable  (accel_read_enable),
    .accel_write_enable (accel_write_enable),
    .accel_read_data    (accel_read_data),
    .accel_write_data   (accel_write_data),
    .data_in            (data_in),
    .data_in_valid      (data_in_valid),
    .data_out           (data_out),
    .data_out_valid     (data_out_valid),
    .data_out_ready     (data_out_ready),
`ifdef FIFO_ACCEL_BRIDGE_DROP_CNT_EN
    .in_drop_count      (in_drop_count),
    .in_overflow        (in_overflow),
`endif
    .in_level           (in_level),
    .out_level          (out_level)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned drops   = 0;
  int unsigned in_pushes = 0;
  int unsigned in_pops   = 0;
  logic [7:0]  in_q[$];
  logic [7:0]  out_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus: compare visible heads/flags with the model, then apply pre-edge rules.
  task automatic cycle(input logic iv, input logic [7:0] id, input logic ren,
                       input logic wen, input logic [15:0] wd, input logic rdy);
    bit in_push, in_pop, out_push, out_pop;
    check("can_read", 32'(accel_can_read), 32'(in_q.size() != 0));
    if (in_q.size() != 0) check("rd_data", 32'(accel_read_data), 32'(in_q[0]));
    check("can_write", 32'(accel_can_write), 32'(out_q.size() < OutCap));
    check("out_valid", 32'(data_out_valid), 32'(out_q.size() != 0));
    if (out_q.size() != 0) check("data_out", 32'(data_out), 32'(out_q[0]));
    data_in_valid      = iv;
    data_in            = id;
    accel_read_enable  = ren;
    accel_write_enable = wen;
    accel_write_data   = wd;
    data_out_ready     = rdy;
    in_push  = iv && (in_q.size() < InCap);
    in_pop   = ren && (in_q.size() != 0);
    out_push = wen && (out_q.size() < OutCap);
    out_pop  = rdy && (out_q.size() != 0);
    if (iv && !in_push) drops++;
    @(posedge clk);
    #1;
    if (in_pop) begin
      void'(in_q.pop_front());
      in_pops++;
    end
    if (in_push) begin
      in_q.push_back(id);
      in_pushes++;
    end
    if (out_pop) void'(out_q.pop_front());
    if (out_push) out_q.push_back(wd[7:0]);
    data_in_valid      = 1'b0;
    accel_read_enable  = 1'b0;
    accel_write_enable = 1'b0;
    data_out_ready     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_q.delete();
    out_q.delete();
    drops = 0;
  endtask

  task automatic check_levels(input string tag);
    check({tag, "_in_level"}, 32'(in_level), 32'(in_q.size()));
    check({tag, "_out_level"}, 32'(out_level), 32'(out_q.size()));
`ifdef FIFO_ACCEL_BRIDGE_DROP_CNT_EN
    check({tag, "_drop_cnt"}, 32'(in_drop_count), drops);
    check({tag, "_overflow"}, 32'(in_overflow), 32'(drops != 0));
`endif
  endtask

  task automatic drain_in();
    while (in_q.size() != 0) cycle(1'b0, 8'h00, 1'b1, 1'b0, 16'h0, 1'b0);
    check("drained_can_read", 32'(accel_can_read), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    data_in_valid = 1'b0; data_in = '0; accel_read_enable = 1'b0;
    accel_write_enable = 1'b0; accel_write_data = '0; data_out_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();
    check("rst_can_read", 32'(accel_can_read), 32'd0);
    check("rst_can_write", 32'(accel_can_write), 32'd1);
    check("rst_out_valid", 32'(data_out_valid), 32'd0);
    check_levels("rst");

    // Reset discards stored words.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 16'h0, 1'b0);
    check_levels("pre_rst");
    do_reset();
    check("rst2_can_read", 32'(accel_can_read), 32'd0);
    check("rst2_can_write", 32'(accel_can_write), 32'd1);
    check_levels("rst2");

    // Inbound fill: 9 pushes into a 7-entry channel, last two dropped.
    for (int i = 1; i <= 9; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 16'h0, 1'b0);
    check_levels("fill");
    check("fill_drops_model", 32'(in_level), 32'd7);
    drain_in();

    // Outbound handshake: 4th write lost, ready toggles 1/0.
    cycle(1'b0, 8'h0, 1'b0, 1'b1, 16'hAB12, 1'b0);
    cycle(1'b0, 8'h0, 1'b0, 1'b1, 16'hCD34, 1'b0);
    cycle(1'b0, 8'h0, 1'b0, 1'b1, 16'hEF56, 1'b0);
    check("out_full_can_write", 32'(accel_can_write), 32'd0);
    cycle(1'b0, 8'h0, 1'b0, 1'b1, 16'h7777, 1'b0);
    check_levels("out_full");
    for (int i = 0; i < 12 && out_q.size() != 0; i++) begin
      cycle(1'b0, 8'h0, 1'b0, 1'b0, 16'h0, 1'(i % 2 == 0));
    end
    check("out_drained_valid", 32'(data_out_valid), 32'd0);
    check_levels("out_drained");

    // Push+pop on a full inbound channel: push refused, level drops to 6.
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 8'h99, 1'b1, 1'b0, 16'h0, 1'b0);
    check("full_simul_level", 32'(in_level), 32'd6);
    check_levels("full_simul");
    drain_in();

    // Push+pop on an empty outbound channel: push lands, pop ignored.
    cycle(1'b0, 8'h0, 1'b0, 1'b1, 16'h0042, 1'b1);
    check("empty_simul_level", 32'(out_level), 32'd1);
    check("empty_simul_valid", 32'(data_out_valid), 32'd1);
    cycle(1'b0, 8'h0, 1'b0, 1'b0, 16'h0, 1'b1);
    check_levels("empty_simul");

    // Wrap-around at level 2 across several pointer laps.
    in_pushes = 0;
    in_pops = 0;
    cycle(1'b1, 8'h50, 1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 8'h51, 1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'(8'h52 + i), 1'b1, 1'b0, 16'h0, 1'b0);
      check("wrap_level", 32'(in_level), 32'd2);
    end
    drain_in();
    check("wrap_count", in_pops, in_pushes);
    check("wrap_pushes", in_pushes, 32'd42);
    check_levels("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
